// File: rtl/multdiv_unit.sv
// ============================================================================
// multdiv_unit: multi-cycle signed multiply/divide; MULTDIV_BOOTH4_EN selects radix-4 Booth multiply.
// Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

`ifdef MULTDIV_BOOTH4_EN
  localparam int              PW       = 2*WIDTH + 3;
  localparam logic [CNT_W-1:0] MUL_ITER = CNT_W'(WIDTH/2);
`else
  localparam int              PW       = 2*WIDTH;
  localparam logic [CNT_W-1:0] MUL_ITER = CNT_W'(WIDTH);
`endif
  localparam logic [CNT_W-1:0] DIV_ITER = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;

  logic               neg;
  logic [WIDTH-1:0]   b_mag, in_a_mag;
  logic [PW-1:0]      mul_next, mul_init;
  logic [2*WIDTH-1:0] mul_full;
  logic               mul_ovf;
  logic [WIDTH:0]     div_rs, div_diff;
  logic [2*WIDTH-1:0] div_next, div_init;
  logic [WIDTH-1:0]   div_q;
  logic               div_ovf;

  assign neg      = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
  assign in_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;

`ifdef MULTDIV_BOOTH4_EN
  // Booth works on the signed operands directly; product sits in prod_q[2W:1].
  logic [WIDTH+1:0] pp, bh_sum;
  always_comb begin
    pp = '0;
    case (prod_q[2:0])
      3'b001, 3'b010: pp = {{2{a_q[WIDTH-1]}}, a_q};
      3'b011:         pp = {a_q[WIDTH-1], a_q, 1'b0};
      3'b100:         pp = -{a_q[WIDTH-1], a_q, 1'b0};
      3'b101, 3'b110: pp = -{{2{a_q[WIDTH-1]}}, a_q};
      default:        pp = '0;
    endcase
  end
  assign bh_sum   = prod_q[PW-1:WIDTH+1] + pp;
  assign mul_next = {{2{bh_sum[WIDTH+1]}}, bh_sum, prod_q[WIDTH:2]};
  assign mul_full = prod_q[2*WIDTH:1];
  assign mul_init = {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
`else
  logic [WIDTH-1:0] a_mag, in_b_mag;
  logic [WIDTH:0]   r2_sum;
  assign a_mag    = a_q[WIDTH-1] ? -a_q : a_q;
  assign in_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign r2_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag} : '0);
  assign mul_next = {r2_sum, prod_q[WIDTH-1:1]};
  assign mul_full = neg ? -prod_q : prod_q;
  assign mul_init = {{WIDTH{1'b0}}, in_b_mag};
`endif

  assign mul_ovf = ~((&mul_full[2*WIDTH-1:WIDTH-1]) | ~(|mul_full[2*WIDTH-1:WIDTH-1]));

  // Restoring divide: {remainder, dividend/quotient} shifts left one bit per step.
  assign div_rs   = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rs - {1'b0, b_mag};
  assign div_next = {div_diff[WIDTH] ? div_rs[WIDTH-1:0] : div_diff[WIDTH-1:0],
                     prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
  assign div_init = {{WIDTH{1'b0}}, in_a_mag};
  assign div_q    = neg ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      MUL: begin
        if (cnt_q == MUL_ITER) begin
          result_d = mul_full[WIDTH-1:0];
          exc_d    = mul_ovf;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else begin
          prod_d = mul_next;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        if (b_q == '0) begin
          result_d = '0;
          exc_d    = 1'b1;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == DIV_ITER) begin
          result_d = div_q;
          exc_d    = div_ovf;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else begin
          prod_d[2*WIDTH-1:0] = div_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    // A start pulse always wins, aborting whatever is in flight.
    if (ctrl_MULT || ctrl_DIV) begin
      a_d    = data_operandA;
      b_d    = data_operandB;
      cnt_d  = '0;
      busy_d = 1'b1;
      rdy_d  = 1'b0;
      if (ctrl_MULT) begin
        state_d = MUL;
        prod_d  = mul_init;
      end else begin
        state_d = DIV;
        prod_d  = '0;
        prod_d[2*WIDTH-1:0] = div_init;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// tb_multdiv_unit: scoreboard bench for multdiv_unit with directed vectors.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (ctrl_reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdy: rdy=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, data_result, e.res);
        chk({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy_in_rdy"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] res, input logic ex, input int lat);
    exp_t t;
    t.res  = res;
    t.exc  = ex;
    t.cyc  = cyc + 1 + lat;
    t.name = name;
    sb.push_back(t);
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                       input bit push, input string name, input logic [31:0] res,
                       input logic ex, input int lat);
    @(negedge clock);
    data_operandA = av;
    data_operandB = bv;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    if (push) push_exp(name, res, ex, lat);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h13572468;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) return;
      @(negedge clock);
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s_timeout: %0d results still pending, expected 0", name, sb.size());
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    ctrl_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 7 * -6 with busy window checks
    issue(1, 0, 32'd7, 32'hFFFFFFFA, 1, "mul_7xm6", 32'hFFFFFFD6, 0, MUL_LAT);
    chk("busy_at_k", {31'd0, busy}, 32'd1);
    repeat (MUL_LAT - 1) @(negedge clock);
    chk("busy_at_last", {31'd0, busy}, 32'd1);
    wait_drain("mul_7xm6");

    issue(1, 0, 32'h00010000, 32'h00010000, 1, "mul_ovf", 32'h0, 1, MUL_LAT);
    wait_drain("mul_ovf");
    issue(1, 0, 32'h7FFFFFFF, 32'd1, 1, "mul_max", 32'h7FFFFFFF, 0, MUL_LAT);
    wait_drain("mul_max");
    issue(1, 0, 32'h80000000, 32'hFFFFFFFF, 1, "mul_min_neg1", 32'h80000000, 1, MUL_LAT);
    wait_drain("mul_min_neg1");
    issue(0, 1, 32'hFFFFFFF9, 32'd2, 1, "div_m7_2", 32'hFFFFFFFD, 0, DIV_LAT);
    wait_drain("div_m7_2");
    issue(0, 1, 32'd100, 32'd7, 1, "div_100_7", 32'd14, 0, DIV_LAT);
    wait_drain("div_100_7");
    issue(0, 1, 32'd5, 32'd0, 1, "div_by_zero", 32'h0, 1, 1);
    wait_drain("div_by_zero");
    issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, "div_ovf", 32'h80000000, 1, DIV_LAT);
    wait_drain("div_ovf");

    // Restart while busy: only the DIV completes
    issue(1, 0, 32'd3, 32'd4, 0, "", 32'h0, 0, 0);
    repeat (9) @(negedge clock);
    issue(0, 1, 32'd20, 32'd5, 1, "div_restart", 32'd4, 0, DIV_LAT);
    wait_drain("div_restart");

    issue(1, 1, 32'd3, 32'd4, 1, "mul_div_both", 32'd12, 0, MUL_LAT);
    wait_drain("mul_div_both");
    repeat (5) @(negedge clock);
    chk("idle_hold_result", data_result, 32'd12);
    chk("idle_hold_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);

    // Start pulse in the DONE cycle
    issue(1, 0, 32'hFFFFFFF8, 32'd5, 1, "mul_m8x5", 32'hFFFFFFD8, 0, MUL_LAT);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (data_resultRDY) found = 1'b1;
      else @(negedge clock);
    end
    chk("done_cycle_seen", {31'd0, found}, 32'd1);
    data_operandA = 32'hFFFFFF9C;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    push_exp("div_in_done", 32'hFFFFFFF2, 0, DIV_LAT);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_drain("div_in_done");

    // Asynchronous reset mid-multiply
    issue(1, 0, 32'd9, 32'd9, 0, "", 32'h0, 0, 0);
    repeat (14) @(negedge clock);
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    #2 ctrl_reset_n = 1'b0;
    #1;
    chk("async_reset_result", data_result, 32'h0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_exc", {31'd0, data_exception}, 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    repeat (45) @(negedge clock);
    issue(1, 0, 32'd2, 32'd2, 1, "mul_after_reset", 32'd4, 0, MUL_LAT);
    wait_drain("mul_after_reset");

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
